fir_coef_ctrl: RTL and testbench
================================

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 Parameter BW, default 12, coefficient word width in bits (signed two's complement).
REQ-002 Parameter N, default 5, number of FIR taps; N >= 2.
REQ-003 CK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 CW_VLD  input  1  coefficient write word valid.
REQ-006 CW_RDY  output  1  controller accepts a word; a transfer occurs on a rising CK edge with CW_VLD=1 and CW_RDY=1.
REQ-007 CW_DATA  input  BW  coefficient word.
REQ-008 CW_LAST  input  1  marks the final word of a set; sampled only on a transfer.
REQ-009 COMMIT  input  1  request to apply the loaded shadow set to the FIR.
REQ-010 C  output  N*BW  active coefficient bus to the FIR; tap k occupies C[(k+1)*BW-1:k*BW].
REQ-011 PEND  output  1  a complete shadow set awaits COMMIT.
REQ-012 SETTLED  output  1  the FIR pipeline holds only products of the current C.
REQ-013 ERR  output  1  one-cycle pulse on a framing error.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WAIT, SETTLE; PEND=1 exactly in WAIT; SETTLED=0 exactly in SETTLE.
REQ-015 CW_RDY SHALL be 1 in IDLE and LOAD, 0 in WAIT and SETTLE.
REQ-016 A 0..N-1 write index SHALL select the shadow slot; word at index k goes to shadow tap k (index 0 = C[BW-1:0]).
REQ-017 IDLE: a transfer writes index 0 and moves to LOAD with index 1; N=1-style completion does not apply (N>=2).
REQ-018 LOAD: each transfer writes the current index and increments it; the transfer at index N-1 moves to WAIT.
REQ-019 CW_LAST=1 on a transfer at index < N-1 SHALL pulse ERR, discard the partial set (shadow content unspecified), reset index to 0, go to IDLE.
REQ-020 CW_LAST=0 on the transfer at index N-1 SHALL pulse ERR, reset index, go to IDLE; the shadow set is not committable.
REQ-021 WAIT: COMMIT=1 SHALL copy the full shadow to C on that edge (C visible next cycle), load settle counter with N-1, go to SETTLE.
REQ-022 SETTLE: the counter decrements each cycle; when it reaches 0 the FSM returns to IDLE, so SETTLED is 0 for exactly N-1 cycles starting the cycle after commit.
REQ-023 COMMIT in IDLE, LOAD, SETTLE SHALL be ignored with no side effect; C changes only per REQ-021.
REQ-024 CW_VLD while CW_RDY=0 SHALL be ignored; the source holds the word until accepted.
REQ-025 C SHALL remain stable during loading; loading never disturbs the active set (double buffering).
REQ-026 ERR SHALL be registered, high for exactly one cycle per error, 0 otherwise.

Reset
REQ-027 On RST=1, asynchronously: state IDLE, index 0, settle counter 0, C all zeros, shadow all zeros, CW_RDY=1, PEND=0, SETTLED=1, ERR=0.
REQ-028 RST asserted mid-load, in WAIT or in SETTLE SHALL abandon the operation; no partial set ever reaches C.
REQ-029 After RST deasserts, the first transfer is accepted on the first following rising edge.

Verification
REQ-030 N=5, BW=12: send 0x001,0x002,0x003,0x004,0x005 (LAST on 5th), then COMMIT -> PEND=1 after 5th word; next cycle C=0x005004003002001; SETTLED=0 for 4 cycles then 1.
REQ-031 LAST on 3rd word -> ERR pulse 1 cycle, state IDLE, C unchanged (0), PEND=0; subsequent full 5-word set loads correctly.
REQ-032 5th word without LAST -> ERR pulse, PEND stays 0, COMMIT afterwards leaves C unchanged.
REQ-033 COMMIT held 1 throughout loading -> no C change until the cycle after WAIT is entered; CW_RDY=0 in WAIT/SETTLE with CW_VLD=1 -> no words consumed.
REQ-034 Random CW_VLD gaps between words -> same C result as back-to-back; RST during 3rd word and during SETTLE -> outputs return immediately to REQ-027 values.
REQ-035 Second set loaded and committed after a first -> C switches atomically from set 1 to set 2 in one edge, never a mix.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
// -----------------------------------------------------------------------------
// fir_coef_ctrl
//
// Double-buffered coefficient loader for an N-tap FIR. Coefficient words are
// streamed into a shadow set over a valid/ready port. A complete set (N
// words, with cw_last_i on exactly the final one) waits in the shadow until
// commit_i copies it to the active bus c_o in a single edge. After a commit,
// settled_o stays low for N-1 cycles while the FIR pipeline flushes products
// of the previous coefficients.
//
// Handshake: a word transfers on a rising ck_i edge where cw_vld_i=1 and
// cw_rdy_o=1. The source must hold cw_data_i/cw_last_i stable until it
// transfers; cw_vld_i while cw_rdy_o=0 is ignored.
//
// Ports
//   ck_i        clock, rising edge
//   rst_i       asynchronous active-high reset
//   cw_vld_i    coefficient word valid
//   cw_rdy_o    controller can accept a word (IDLE, LOAD)
//   cw_data_i   coefficient word, signed, BW bits
//   cw_last_i   final word of a set, sampled on a transfer only
//   commit_i    apply the pending shadow set to c_o (honoured in WAIT only)
//   c_o         active coefficients, tap k at c_o[(k+1)*BW-1:k*BW]
//   pend_o      a complete shadow set awaits commit (WAIT)
//   settled_o   FIR pipeline holds only products of the current c_o
//   err_o       one-cycle pulse on a framing error
//   state_o     FSM state for debug: 0 IDLE, 1 LOAD, 2 WAIT, 3 SETTLE
// -----------------------------------------------------------------------------
module fir_coef_ctrl #(
    parameter int BW = 12,
    parameter int N  = 5
) (
    input  logic            ck_i,
    input  logic            rst_i,
    input  logic            cw_vld_i,
    output logic            cw_rdy_o,
    input  logic [BW-1:0]   cw_data_i,
    input  logic            cw_last_i,
    input  logic            commit_i,
    output logic [N*BW-1:0] c_o,
    output logic            pend_o,
    output logic            settled_o,
    output logic            err_o,
    output logic [1:0]      state_o
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [IW-1:0] SETTLE_LEN = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     cnt_q;
    logic [N*BW-1:0]   shadow_q;
    logic [N*BW-1:0]   c_q;
    logic              rdy_q;
    logic              pend_q;
    logic              settled_q;
    logic              err_q;
    logic              xfer;

    assign xfer = cw_vld_i & rdy_q;

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            c_q       <= '0;
            rdy_q     <= 1'b1;
            pend_q    <= 1'b0;
            settled_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                // IDLE and LOAD share the write path: idx_q is 0 in IDLE, so
                // the first word lands in tap 0 without a special case.
                S_IDLE, S_LOAD: begin
                    if (xfer) begin
                        shadow_q[int'(idx_q)*BW +: BW] <= cw_data_i;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (cw_last_i) begin
                                state_q <= S_WAIT;
                                rdy_q   <= 1'b0;
                                pend_q  <= 1'b1;
                            end else begin
                                // Set too long: never becomes committable.
                                state_q <= S_IDLE;
                                err_q   <= 1'b1;
                            end
                        end else if (cw_last_i) begin
                            // Set too short: drop the partial set.
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (commit_i) begin
                        c_q       <= shadow_q;
                        cnt_q     <= SETTLE_LEN;
                        state_q   <= S_SETTLE;
                        pend_q    <= 1'b0;
                        settled_q <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    // Leaving on the edge where the count hits 0 keeps
                    // settled_o low for exactly N-1 cycles.
                    cnt_q <= cnt_q - IW'(1);
                    if (cnt_q == IW'(1)) begin
                        state_q   <= S_IDLE;
                        settled_q <= 1'b1;
                        rdy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cw_rdy_o  = rdy_q;
    assign c_o       = c_q;
    assign pend_o    = pend_q;
    assign settled_o = settled_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_ctrl
//
// Self-checking bench for fir_coef_ctrl (N=5, BW=12). The reference model is
// a set-level view: each correctly framed set is packed into the expected
// coefficient bus and queued in exp_q; a commit on a pending set pops it into
// exp_c; a reset empties the queue and zeros exp_c.
// -----------------------------------------------------------------------------
module tb_fir_coef_ctrl;

    localparam int BW = 12;
    localparam int N  = 5;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef logic [BW-1:0] set_t [N];

    logic            ck = 1'b0;
    logic            rst = 1'b0;
    logic            cw_vld = 1'b0;
    logic            cw_rdy_o;
    logic [BW-1:0]   cw_data = '0;
    logic            cw_last = 1'b0;
    logic            commit = 1'b0;
    logic [N*BW-1:0] c_o;
    logic            pend_o;
    logic            settled_o;
    logic            err_o;
    logic [1:0]      state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [N*BW-1:0] exp_q[$];
    logic [N*BW-1:0] exp_c = '0;

    fir_coef_ctrl #(.BW(BW), .N(N)) dut (
        .ck_i      (ck),
        .rst_i     (rst),
        .cw_vld_i  (cw_vld),
        .cw_rdy_o  (cw_rdy_o),
        .cw_data_i (cw_data),
        .cw_last_i (cw_last),
        .commit_i  (commit),
        .c_o       (c_o),
        .pend_o    (pend_o),
        .settled_o (settled_o),
        .err_o     (err_o),
        .state_o   (state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 ck = ~ck;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [N*BW-1:0] pack(input set_t s);
        logic [N*BW-1:0] r;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = s[k];
        return r;
    endfunction

    function automatic set_t rand_set();
        set_t s;
        for (int k = 0; k < N; k++) s[k] = BW'($urandom);
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        exp_q.delete();
        exp_c = '0;
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [BW-1:0] d, input logic last, input int gap);
        int w;
        cw_vld = 1'b0;
        repeat (gap) tick();
        cw_vld  = 1'b1;
        cw_data = d;
        cw_last = last;
        w = 0;
        while (cw_rdy_o !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (cw_rdy_o !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout rdy=%b required=1", cw_rdy_o);
        end
        tick();
        cw_vld  = 1'b0;
        cw_last = 1'b0;
    endtask

    // kind 0: good set, 1: last early at pos, 2: no last on final word
    task automatic load_set(input set_t s, input int kind, input int pos, input int max_gap);
        for (int k = 0; k < N; k++) begin
            if (kind == 1 && k == pos) begin
                send_word(s[k], 1'b1, $urandom_range(0, max_gap));
                return;
            end
            send_word(s[k], (k == N-1) && (kind != 2), $urandom_range(0, max_gap));
        end
        if (kind == 0) exp_q.push_back(pack(s));
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        if (exp_q.size() > 0) exp_c = exp_q.pop_front();
    endtask

    task automatic measure_settle(output int cycles);
        cycles = 0;
        while (settled_o === 1'b0 && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (c_o !== '0 || cw_rdy_o !== 1'b1 || pend_o !== 1'b0 || settled_o !== 1'b1 ||
            err_o !== 1'b0 || state_o !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_values c=%h rdy=%b pend=%b settled=%b err=%b st=%0d required c=0 rdy=1 pend=0 settled=1 err=0 st=0",
                     c_o, cw_rdy_o, pend_o, settled_o, err_o, state_o);
        end
        // first word must be accepted on the first edge after release
        @(negedge ck);
        rst = 1'b0;
        cw_vld = 1'b1;
        cw_data = 12'h0AB;
        cw_last = 1'b0;
        tick();
        cw_vld = 1'b0;
        n_checks++;
        if (state_o !== ST_LOAD) begin
            n_errors++;
            $display("FAIL reset_first_xfer state=%0d required=%0d", state_o, ST_LOAD);
        end
        do_reset();
    endtask

    task automatic test_basic();
        set_t s;
        int cyc;
        for (int k = 0; k < N; k++) s[k] = BW'(k + 1);
        for (int k = 0; k < N; k++) begin
            send_word(s[k], k == N-1, 0);
            n_checks++;
            if (pend_o !== (k == N-1) || c_o !== exp_c) begin
                n_errors++;
                $display("FAIL basic_load k=%0d pend=%b c=%h required pend=%b c=%h",
                         k, pend_o, c_o, (k == N-1), exp_c);
            end
        end
        exp_q.push_back(pack(s));
        n_checks++;
        if (cw_rdy_o !== 1'b0 || state_o !== ST_WAIT) begin
            n_errors++;
            $display("FAIL basic_wait rdy=%b st=%0d required rdy=0 st=%0d", cw_rdy_o, state_o, ST_WAIT);
        end
        do_commit();
        n_checks++;
        if (c_o !== 60'h005004003002001 || settled_o !== 1'b0 || pend_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_commit c=%h settled=%b pend=%b required c=005004003002001 settled=0 pend=0",
                     c_o, settled_o, pend_o);
        end
        measure_settle(cyc);
        n_checks++;
        if (cyc !== N-1 || cw_rdy_o !== 1'b1 || state_o !== ST_IDLE) begin
            n_errors++;
            $display("FAIL basic_settle cycles=%0d rdy=%b st=%0d required cycles=%0d rdy=1 st=0",
                     cyc, cw_rdy_o, state_o, N-1);
        end
    endtask

    task automatic test_early_last();
        int cyc;
        load_set(rand_set(), 1, 2, 2);
        n_checks++;
        if (err_o !== 1'b1 || pend_o !== 1'b0 || state_o !== ST_IDLE || c_o !== exp_c) begin
            n_errors++;
            $display("FAIL early_last err=%b pend=%b st=%0d c=%h required err=1 pend=0 st=0 c=%h",
                     err_o, pend_o, state_o, c_o, exp_c);
        end
        tick();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL early_last_pulse err=%b required=0", err_o);
        end
        load_set(rand_set(), 0, 0, 3);
        do_commit();
        n_checks++;
        if (c_o !== exp_c) begin
            n_errors++;
            $display("FAIL early_last_reload c=%h required=%h", c_o, exp_c);
        end
        measure_settle(cyc);
    endtask

    task automatic test_missing_last();
        load_set(rand_set(), 2, 0, 1);
        n_checks++;
        if (err_o !== 1'b1 || pend_o !== 1'b0 || cw_rdy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL missing_last err=%b pend=%b rdy=%b required err=1 pend=0 rdy=1",
                     err_o, pend_o, cw_rdy_o);
        end
        do_commit();
        tick();
        n_checks++;
        if (c_o !== exp_c || err_o !== 1'b0 || settled_o !== 1'b1 || state_o !== ST_IDLE) begin
            n_errors++;
            $display("FAIL missing_last_commit c=%h err=%b settled=%b st=%0d required c=%h err=0 settled=1 st=0",
                     c_o, err_o, settled_o, state_o, exp_c);
        end
    endtask

    task automatic test_commit_hold();
        set_t s;
        logic [N*BW-1:0] old_c;
        int cyc;
        int w;
        s = rand_set();
        old_c = exp_c;
        commit = 1'b1;
        for (int k = 0; k < N; k++) begin
            send_word(s[k], k == N-1, $urandom_range(0, 2));
            n_checks++;
            if (c_o !== old_c) begin
                n_errors++;
                $display("FAIL hold_load k=%0d c=%h required=%h", k, c_o, old_c);
            end
        end
        tick();
        commit = 1'b0;
        exp_c = pack(s);
        n_checks++;
        if (c_o !== exp_c || settled_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_commit c=%h settled=%b required c=%h settled=0", c_o, settled_o, exp_c);
        end
        measure_settle(cyc);
        // words offered in WAIT and SETTLE must not be consumed
        load_set(rand_set(), 0, 0, 0);
        cw_vld = 1'b1;
        cw_data = 12'hBAD;
        cw_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pend_o !== 1'b1 || cw_rdy_o !== 1'b0 || err_o !== 1'b0) begin
                n_errors++;
                $display("FAIL wait_ignore pend=%b rdy=%b err=%b required pend=1 rdy=0 err=0",
                         pend_o, cw_rdy_o, err_o);
            end
        end
        do_commit();
        w = 0;
        while (settled_o === 1'b0 && w < 40) begin
            tick();
            w++;
        end
        cw_vld = 1'b0;
        cw_last = 1'b0;
        n_checks++;
        if (c_o !== exp_c || state_o !== ST_IDLE || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL settle_ignore c=%h st=%0d err=%b required c=%h st=0 err=0",
                     c_o, state_o, err_o, exp_c);
        end
        load_set(rand_set(), 0, 0, 1);
        do_commit();
        n_checks++;
        if (c_o !== exp_c) begin
            n_errors++;
            $display("FAIL after_ignore c=%h required=%h", c_o, exp_c);
        end
        measure_settle(cyc);
    endtask

    task automatic test_reset_mid();
        set_t s;
        s = rand_set();
        send_word(s[0], 1'b0, 0);
        send_word(s[1], 1'b0, 1);
        cw_vld = 1'b1;
        cw_data = s[2];
        @(negedge ck);
        rst = 1'b1;
        exp_q.delete();
        exp_c = '0;
        #1;
        n_checks++;
        if (c_o !== exp_c || cw_rdy_o !== 1'b1 || pend_o !== 1'b0 || settled_o !== 1'b1 ||
            err_o !== 1'b0 || state_o !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_mid_load c=%h rdy=%b pend=%b settled=%b err=%b st=%0d required all reset values",
                     c_o, cw_rdy_o, pend_o, settled_o, err_o, state_o);
        end
        cw_vld = 1'b0;
        @(negedge ck);
        rst = 1'b0;
        load_set(rand_set(), 0, 0, 1);
        do_commit();
        n_checks++;
        if (c_o !== exp_c) begin
            n_errors++;
            $display("FAIL reset_reload c=%h required=%h", c_o, exp_c);
        end
        tick();
        #2 rst = 1'b1;
        exp_c = '0;
        #1;
        n_checks++;
        if (c_o !== exp_c || settled_o !== 1'b1 || cw_rdy_o !== 1'b1 || state_o !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_mid_settle c=%h settled=%b rdy=%b st=%0d required c=0 settled=1 rdy=1 st=0",
                     c_o, settled_o, cw_rdy_o, state_o);
        end
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_t sa;
        set_t sb;
        int cyc;
        sa = rand_set();
        sb = rand_set();
        load_set(sa, 0, 0, 0);
        do_commit();
        measure_settle(cyc);
        for (int k = 0; k < N; k++) begin
            send_word(sb[k], k == N-1, $urandom_range(0, 3));
            n_checks++;
            if (c_o !== pack(sa)) begin
                n_errors++;
                $display("FAIL b2b_stable k=%0d c=%h required=%h", k, c_o, pack(sa));
            end
        end
        exp_q.push_back(pack(sb));
        do_commit();
        n_checks++;
        if (c_o !== pack(sb) || c_o !== exp_c) begin
            n_errors++;
            $display("FAIL b2b_switch c=%h required=%h", c_o, pack(sb));
        end
        measure_settle(cyc);
    endtask

    task automatic test_random();
        int kind;
        int pos;
        int cyc;
        logic exp_err;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            pos  = $urandom_range(0, N-2);
            load_set(rand_set(), kind, pos, 3);
            exp_err = (kind != 0);
            n_checks++;
            if (err_o !== exp_err || pend_o !== !exp_err) begin
                n_errors++;
                $display("FAIL rand_frame it=%0d kind=%0d err=%b pend=%b required err=%b pend=%b",
                         it, kind, err_o, pend_o, exp_err, !exp_err);
            end
            do_commit();
            n_checks++;
            if (c_o !== exp_c) begin
                n_errors++;
                $display("FAIL rand_commit it=%0d c=%h required=%h", it, c_o, exp_c);
            end
            measure_settle(cyc);
            n_checks++;
            if (cyc !== (exp_err ? 0 : N-1)) begin
                n_errors++;
                $display("FAIL rand_settle it=%0d cycles=%0d required=%0d", it, cyc, exp_err ? 0 : N-1);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_early_last();
        test_missing_last();
        test_commit_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
